// File: rtl/audio_adc_receiver.sv
// I2S ADC receiver: synchronizes the codec's BCLK/LRCK/DAT into Clk, deserializes left/right
// words and queues complete stereo pairs in a small show-ahead FIFO with a valid/ready handshake.
module audio_adc_receiver #(
  parameter int unsigned SAMPLE_W    = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                          Clk,
  input  logic                          Reset_N,
  input  logic                          en,
  input  logic                          AUD_BCLK,
  input  logic                          AUD_ADCLRCK,
  input  logic                          AUD_ADCDAT,
  output logic [SAMPLE_W-1:0]           sample_left,
  output logic [SAMPLE_W-1:0]           sample_right,
  output logic                          sample_valid,
  input  logic                          sample_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          short_word,
  input  logic                          clear_flags
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(SAMPLE_W + 1);
  localparam logic [CW-1:0] W_C     = CW'(SAMPLE_W);
  localparam logic [LW-1:0] DEPTH_C = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SKIP, SHIFT, DRAIN} state_t;

  logic [SYNC_STAGES-1:0] bclk_sync_q, lrck_sync_q, dat_sync_q;
  logic bclk_prev_q, lrck_last_q;
  logic bclk_s, lrck_s, dat_s, bclk_rise, lrck_edge;

  assign bclk_s    = bclk_sync_q[SYNC_STAGES-1];
  assign lrck_s    = lrck_sync_q[SYNC_STAGES-1];
  assign dat_s     = dat_sync_q[SYNC_STAGES-1];
  assign bclk_rise = bclk_s & ~bclk_prev_q;
  assign lrck_edge = bclk_rise & (lrck_s ^ lrck_last_q);

  always_ff @(posedge Clk) begin
    if (!Reset_N) begin
      bclk_sync_q <= '0;
      lrck_sync_q <= '0;
      dat_sync_q  <= '0;
      bclk_prev_q <= 1'b0;
      lrck_last_q <= 1'b0;
    end else begin
      bclk_sync_q <= {bclk_sync_q[SYNC_STAGES-2:0], AUD_BCLK};
      lrck_sync_q <= {lrck_sync_q[SYNC_STAGES-2:0], AUD_ADCLRCK};
      dat_sync_q  <= {dat_sync_q[SYNC_STAGES-2:0], AUD_ADCDAT};
      bclk_prev_q <= bclk_s;
      if (bclk_rise) lrck_last_q <= lrck_s;
    end
  end

  state_t              state_q, state_d;
  logic                ch_q, ch_d;            // 0 = left word in progress, 1 = right
  logic [CW-1:0]       cnt_q, cnt_d, cnt_inc;
  logic [SAMPLE_W-1:0] word_q, word_d, shifted, justified, latch_word;
  logic [SAMPLE_W-1:0] left_hold_q, left_hold_d, push_right_q, push_right_d;
  logic                left_got_q, left_got_d, push_q, push_d, latch_en, short_set;

  assign cnt_inc   = cnt_q + CW'(1);
  assign shifted   = {word_q[SAMPLE_W-2:0], dat_s};
  assign justified = word_q << (W_C - cnt_q);

  always_comb begin
    state_d      = state_q;
    ch_d         = ch_q;
    cnt_d        = cnt_q;
    word_d       = word_q;
    left_hold_d  = left_hold_q;
    left_got_d   = left_got_q;
    push_right_d = push_right_q;
    push_d       = 1'b0;
    latch_en     = 1'b0;
    latch_word   = '0;
    short_set    = 1'b0;
    if (!en) begin
      state_d    = IDLE;
      left_got_d = 1'b0;
    end else if (bclk_rise) begin
      case (state_q)
        IDLE: if (lrck_last_q && !lrck_s) begin
          state_d = SKIP;
          ch_d    = 1'b0;
        end
        // The rise after the LRCK edge carries the previous word's tail; this one carries the MSB.
        SKIP: if (lrck_edge) begin
          ch_d = lrck_s;
        end else begin
          word_d  = {{(SAMPLE_W-1){1'b0}}, dat_s};
          cnt_d   = CW'(1);
          state_d = SHIFT;
        end
        SHIFT: if (lrck_edge) begin
          latch_en   = 1'b1;
          latch_word = justified;
          short_set  = 1'b1;
          ch_d       = lrck_s;
          state_d    = SKIP;
        end else begin
          word_d = shifted;
          cnt_d  = cnt_inc;
          if (cnt_inc == W_C) begin
            latch_en   = 1'b1;
            latch_word = shifted;
            state_d    = DRAIN;
          end
        end
        DRAIN: if (lrck_edge) begin
          ch_d    = lrck_s;
          state_d = SKIP;
        end
      endcase
      if (latch_en) begin
        if (!ch_q) begin
          left_hold_d = latch_word;
          left_got_d  = 1'b1;
        end else begin
          push_d       = left_got_q;
          push_right_d = latch_word;
          left_got_d   = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_N) begin
      state_q      <= IDLE;
      ch_q         <= 1'b0;
      cnt_q        <= '0;
      word_q       <= '0;
      left_hold_q  <= '0;
      left_got_q   <= 1'b0;
      push_q       <= 1'b0;
      push_right_q <= '0;
    end else begin
      state_q      <= state_d;
      ch_q         <= ch_d;
      cnt_q        <= cnt_d;
      word_q       <= word_d;
      left_hold_q  <= left_hold_d;
      left_got_q   <= left_got_d;
      push_q       <= push_d;
      push_right_q <= push_right_d;
    end
  end

  logic [SAMPLE_W-1:0] mem_l [FIFO_DEPTH];
  logic [SAMPLE_W-1:0] mem_r [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]       level_q, level_d;
  logic [SAMPLE_W-1:0] head_l_q, head_r_q, head_l_d, head_r_d;
  logic                overflow_q, short_q, pop, full, push_acc, head_is_new;

  assign sample_valid = (level_q != '0);
  assign pop          = sample_valid & sample_ready;
  assign full         = (level_q == DEPTH_C);
  assign push_acc     = push_q & (~full | pop);
  assign rd_ptr_d     = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
  // A pair written this cycle into the slot that becomes the head must bypass the array.
  assign head_is_new  = push_acc & (wr_ptr_q == rd_ptr_d);
  assign head_l_d     = head_is_new ? left_hold_q  : mem_l[rd_ptr_d];
  assign head_r_d     = head_is_new ? push_right_q : mem_r[rd_ptr_d];

  always_comb begin
    level_d = level_q;
    if (push_acc && !pop)      level_d = level_q + LW'(1);
    else if (!push_acc && pop) level_d = level_q - LW'(1);
  end

  always_ff @(posedge Clk) begin
    if (push_acc) begin
      mem_l[wr_ptr_q] <= left_hold_q;
      mem_r[wr_ptr_q] <= push_right_q;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_N) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      head_l_q   <= '0;
      head_r_q   <= '0;
      overflow_q <= 1'b0;
      short_q    <= 1'b0;
    end else begin
      if (push_acc) wr_ptr_q <= wr_ptr_q + AW'(1);
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      if (level_d != '0) begin
        head_l_q <= head_l_d;
        head_r_q <= head_r_d;
      end
      overflow_q <= (push_q & full & ~pop) | (overflow_q & ~clear_flags);
      short_q    <= short_set | (short_q & ~clear_flags);
    end
  end

  assign sample_left  = head_l_q;
  assign sample_right = head_r_q;
  assign fifo_level   = level_q;
  assign overflow     = overflow_q;
  assign short_word   = short_q;
endmodule

// File: tb/tb_audio_adc_receiver.sv
// Directed bench for audio_adc_receiver: drives an I2S stream at Clk/16 and checks the
// captured pairs, FIFO level/ordering, sticky flags, enable and reset handling.
module tb_audio_adc_receiver;
  logic        Clk = 1'b0;
  logic        Reset_N = 1'b0;
  logic        en = 1'b0;
  logic        bclk = 1'b0;
  logic        lrck = 1'b0;
  logic        dat = 1'b0;
  logic        ready = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] sample_left, sample_right;
  logic        sample_valid, overflow, short_word;
  logic [2:0]  fifo_level;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lsb_cyc = 0;
  int rise_cyc = -1;
  logic vprev = 1'b0;

  audio_adc_receiver #(.SAMPLE_W(16), .SYNC_STAGES(2), .FIFO_DEPTH(4)) dut (
    .Clk(Clk), .Reset_N(Reset_N), .en(en),
    .AUD_BCLK(bclk), .AUD_ADCLRCK(lrck), .AUD_ADCDAT(dat),
    .sample_left(sample_left), .sample_right(sample_right),
    .sample_valid(sample_valid), .sample_ready(ready),
    .fifo_level(fifo_level), .overflow(overflow), .short_word(short_word),
    .clear_flags(clear)
  );

  always #10 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;
  always @(negedge Clk) begin
    if (sample_valid && !vprev) rise_cyc = cyc;
    vprev = sample_valid;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One channel slot: bit j=0 is the previous word's tail (pad 1), bits 1..nbits carry word MSB-first.
  task automatic send_slot(input logic lr, input logic [15:0] w, input int nbits,
                           input int slot_len, input bit pop_at_push);
    for (int j = 0; j < slot_len; j++) begin
      bclk = 1'b0;
      lrck = lr;
      dat  = (j >= 1 && j <= nbits) ? w[16-j] : 1'b1;
      repeat (8) @(posedge Clk);
      #1 bclk = 1'b1;
      if (lr && nbits == 16 && j == 16) lsb_cyc = cyc;
      if (pop_at_push && j == nbits) begin
        repeat (3) @(posedge Clk);
        #1 ready = 1'b1;
        @(posedge Clk);
        #1 ready = 1'b0;
        repeat (4) @(posedge Clk);
        #1;
      end else begin
        repeat (8) @(posedge Clk);
        #1;
      end
    end
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
    send_slot(1'b0, l, 16, 24, 1'b0);
    send_slot(1'b1, r, 16, 24, 1'b0);
    $display("frame sent L=%h R=%h level=%0d", l, r, fifo_level);
  endtask

  task automatic pop_chk(input string tag, input logic [15:0] l, input logic [15:0] r);
    chk({tag, "_valid"}, 32'(sample_valid), 32'd1);
    chk({tag, "_left"}, 32'(sample_left), 32'(l));
    chk({tag, "_right"}, 32'(sample_right), 32'(r));
    $display("pop %s L=%h R=%h", tag, sample_left, sample_right);
    ready = 1'b1;
    @(posedge Clk);
    #1 ready = 1'b0;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_left"}, 32'(sample_left), 32'd0);
    chk({tag, "_right"}, 32'(sample_right), 32'd0);
    chk({tag, "_valid"}, 32'(sample_valid), 32'd0);
    chk({tag, "_level"}, 32'(fifo_level), 32'd0);
    chk({tag, "_ovf"}, 32'(overflow), 32'd0);
    chk({tag, "_short"}, 32'(short_word), 32'd0);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge Clk);
    #1 clear = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge Clk);
    #1 chk_zero_outputs("reset");
    Reset_N = 1'b1;
    en = 1'b1;

    // Basic pair with 24-bit slots, plus push latency from the right LSB rise
    send_slot(1'b1, 16'h0000, 0, 4, 1'b0);
    send_frame(16'hA5C3, 16'h0F0F);
    chk("t1_level", 32'(fifo_level), 32'd1);
    chk("t1_latency", 32'(rise_cyc - lsb_cyc), 32'd4);
    chk("t1_short", 32'(short_word), 32'd0);
    pop_chk("t1", 16'hA5C3, 16'h0F0F);
    chk("t1_empty", 32'(sample_valid), 32'd0);
    chk("t1_hold", 32'(sample_left), 32'hA5C3);

    // Overflow drops the fifth pair
    for (int n = 1; n <= 5; n++) send_frame(16'(n), ~16'(n));
    chk("t2_level", 32'(fifo_level), 32'd4);
    chk("t2_ovf", 32'(overflow), 32'd1);
    for (int n = 1; n <= 4; n++) pop_chk($sformatf("t2_pop%0d", n), 16'(n), ~16'(n));
    chk("t2_drained", 32'(fifo_level), 32'd0);
    pulse_clear();
    chk("t2_ovf_clr", 32'(overflow), 32'd0);

    // Push coinciding with a pop while full
    for (int n = 11; n <= 14; n++) send_frame(16'(n), ~16'(n));
    chk("t3_full", 32'(fifo_level), 32'd4);
    send_slot(1'b0, 16'd15, 16, 24, 1'b0);
    send_slot(1'b1, ~16'd15, 16, 24, 1'b1);
    chk("t3_level", 32'(fifo_level), 32'd4);
    chk("t3_ovf", 32'(overflow), 32'd0);
    for (int n = 12; n <= 15; n++) pop_chk($sformatf("t3_pop%0d", n), 16'(n), ~16'(n));

    // Short left word of ten 1s
    send_slot(1'b0, 16'hFFC0, 10, 11, 1'b0);
    send_slot(1'b1, 16'h1234, 16, 24, 1'b0);
    chk("t4_short", 32'(short_word), 32'd1);
    chk("t4_level", 32'(fifo_level), 32'd1);
    pulse_clear();
    chk("t4_short_clr", 32'(short_word), 32'd0);
    pop_chk("t4", 16'hFFC0, 16'h1234);

    // Enable dropped in the middle of a right word
    send_slot(1'b0, 16'hAAAA, 16, 24, 1'b0);
    send_slot(1'b1, 16'h5555, 16, 8, 1'b0);
    en = 1'b0;
    send_slot(1'b1, 16'h0000, 0, 16, 1'b0);
    for (int k = 1; k <= 3; k++) send_frame(16'h0101 * 16'(k), 16'h1010 * 16'(k));
    chk("t5_no_partial", 32'(fifo_level), 32'd0);
    en = 1'b1;
    send_frame(16'h1357, 16'h2468);
    chk("t5_level", 32'(fifo_level), 32'd1);
    pop_chk("t5", 16'h1357, 16'h2468);

    // Reset in the middle of a left word with two pairs queued
    send_frame(16'h0A0A, 16'h0B0B);
    send_frame(16'h0C0C, 16'h0D0D);
    chk("t6_level2", 32'(fifo_level), 32'd2);
    send_slot(1'b0, 16'h1111, 16, 8, 1'b0);
    Reset_N = 1'b0;
    @(posedge Clk);
    #1 chk_zero_outputs("t6_reset");
    Reset_N = 1'b1;
    send_slot(1'b0, 16'h0000, 0, 16, 1'b0);
    send_slot(1'b1, 16'h9999, 16, 24, 1'b0);
    chk("t6_realign", 32'(fifo_level), 32'd0);
    send_frame(16'h7777, 16'h8888);
    chk("t6_level", 32'(fifo_level), 32'd1);
    pop_chk("t6", 16'h7777, 16'h8888);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
